// File: rtl/cd_spi_csr_bridge.sv
// SPI mode-0 slave that turns host byte streams into cdbus CSR accesses.
// Ports: clk/reset (sync, active-high); spi_sck/nss/mosi in, spi_miso/_oe out;
//   chip_select, csr_address, csr_read/csr_readdata, csr_write/csr_writedata.
module cd_spi_csr_bridge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sck,
    input  logic       spi_nss,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       chip_select,
    output logic [4:0] csr_address,
    output logic       csr_read,
    input  logic [7:0] csr_readdata,
    output logic       csr_write,
    output logic [7:0] csr_writedata
);

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] nss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_hist_q;
    logic                   nss_hist_q;

    state_t     state_q;
    logic [2:0] bitcnt_q;
    logic [6:0] rx_shift_q;
    logic [7:0] tx_shift_q;
    logic       load_q;
    logic       cs_q;
    logic [4:0] addr_q;
    logic       rd_q;
    logic       wr_q;
    logic [7:0] wdata_q;

    logic       sck_s;
    logic       nss_s;
    logic       mosi_s;
    logic       sck_rise;
    logic       sck_fall;
    logic       nss_fall;
    logic [7:0] rx_d;

    // Sync flops reset low: a host still holding NSS low across reset
    // produces no falling edge, so nothing restarts until a fresh select.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync_q  <= '0;
            nss_sync_q  <= '0;
            mosi_sync_q <= '0;
            sck_hist_q  <= 1'b0;
            nss_hist_q  <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            nss_sync_q  <= {nss_sync_q[SYNC_STAGES-2:0], spi_nss};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_hist_q  <= sck_s;
            nss_hist_q  <= nss_s;
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign nss_s    = nss_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_hist_q;
    assign sck_fall = ~sck_s & sck_hist_q;
    assign nss_fall = ~nss_s & nss_hist_q;
    assign rx_d     = {rx_shift_q, mosi_s};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bitcnt_q   <= 3'd0;
            rx_shift_q <= 7'd0;
            tx_shift_q <= 8'd0;
            load_q     <= 1'b0;
            cs_q       <= 1'b0;
            addr_q     <= 5'd0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= 8'd0;
        end else begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            cs_q <= ~nss_s;
            // Deselect has priority over any edge seen in the same clock.
            if (nss_s) begin
                state_q    <= IDLE;
                bitcnt_q   <= 3'd0;
                tx_shift_q <= 8'd0;
                load_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (nss_fall) begin
                            state_q  <= CMD;
                            bitcnt_q <= 3'd0;
                        end
                    end
                    CMD: begin
                        if (sck_rise) begin
                            rx_shift_q <= rx_d[6:0];
                            bitcnt_q   <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                addr_q <= rx_d[4:0];
                                if (rx_d[7]) begin
                                    state_q <= WDATA;
                                end else begin
                                    state_q <= RDATA;
                                    load_q  <= 1'b1;
                                end
                            end
                        end
                    end
                    WDATA: begin
                        if (sck_rise) begin
                            rx_shift_q <= rx_d[6:0];
                            bitcnt_q   <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                wr_q    <= 1'b1;
                                wdata_q <= rx_d;
                            end
                        end
                    end
                    RDATA: begin
                        // Peek fills MISO early; the read strobe waits for
                        // the host to actually clock the byte.
                        if (load_q) begin
                            tx_shift_q <= csr_readdata;
                            load_q     <= 1'b0;
                        end
                        if (sck_rise) begin
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd0) rd_q <= 1'b1;
                            if (bitcnt_q == 3'd7) load_q <= 1'b1;
                        end else if (sck_fall && bitcnt_q != 3'd0) begin
                            tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign spi_miso      = tx_shift_q[7];
    assign spi_miso_oe   = cs_q;
    assign chip_select   = cs_q;
    assign csr_address   = addr_q;
    assign csr_read      = rd_q;
    assign csr_write     = wr_q;
    assign csr_writedata = wdata_q;

endmodule

// File: tb/tb_cd_spi_csr_bridge.sv
// Directed bench for cd_spi_csr_bridge: host-side SPI driver, CSR model
// and a per-cycle monitor comparing strobes and select against expectations.
module tb_cd_spi_csr_bridge;

    localparam int SS   = 2;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_sck;
    logic       spi_nss;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       chip_select;
    logic [4:0] csr_address;
    logic       csr_read;
    logic [7:0] csr_readdata;
    logic       csr_write;
    logic [7:0] csr_writedata;

    cd_spi_csr_bridge #(.SYNC_STAGES(SS)) dut (
        .clk          (clk),
        .reset        (reset),
        .spi_sck      (spi_sck),
        .spi_nss      (spi_nss),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .chip_select  (chip_select),
        .csr_address  (csr_address),
        .csr_read     (csr_read),
        .csr_readdata (csr_readdata),
        .csr_write    (csr_write),
        .csr_writedata(csr_writedata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int nreads = 0;
    int nwrites = 0;
    int rd_mark = 0;
    int since_rst = 0;
    logic [7:0]  rd_base = 8'h00;
    logic [4:0]  exp_rd_addr = 5'd0;
    logic [12:0] exp_wr[$];
    logic [SS:0] nss_hist;

    // CSR model: read data advances by one per committed read.
    assign csr_readdata = rd_base + 8'(nreads - rd_mark);

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic        exp_cs;
        logic [12:0] e;
        forever begin
            @(posedge clk);
            for (int i = SS; i > 0; i--) nss_hist[i] = nss_hist[i-1];
            nss_hist[0] = spi_nss;
            #1;
            if (reset) since_rst = 0;
            else if (since_rst < 1000) since_rst++;
            if (!reset && since_rst > SS) begin
                exp_cs = !nss_hist[SS];
                check("chip_select", 32'(chip_select), 32'(exp_cs));
                check("miso_oe", 32'(spi_miso_oe), 32'(exp_cs));
                if (!exp_cs) check("miso_idle", 32'(spi_miso), 32'd0);
            end
            check("rd_wr_excl", 32'(csr_read & csr_write), 32'd0);
            if (csr_write) begin
                nwrites++;
                check("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
                if (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(csr_address), 32'(e[12:8]));
                    check("wr_data", 32'(csr_writedata), 32'(e[7:0]));
                end
            end
            if (csr_read) begin
                nreads++;
                check("rd_addr", 32'(csr_address), 32'(exp_rd_addr));
            end
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits,
                        output logic [7:0] rx);
        rx = 8'd0;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            wait_clk(HALF);
            rx[i] = spi_miso;
            spi_sck = 1'b1;
            wait_clk(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic txn_begin();
        spi_nss = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic txn_end();
        wait_clk(HALF);
        spi_nss = 1'b1;
        wait_clk(2 * HALF);
    endtask

    logic [7:0] rx;
    logic [7:0] lit4 [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    int w0;
    int r0;

    initial begin
        fork
            monitor();
            begin
                #1000000;
                $display("FAIL watchdog: simulation exceeded time limit");
                $fatal(1);
            end
        join_none

        reset = 1'b1; spi_nss = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        wait_clk(3);
        check("rst_cs", 32'(chip_select), 32'd0);
        check("rst_oe", 32'(spi_miso_oe), 32'd0);
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_strobes", 32'({csr_read, csr_write}), 32'd0);
        check("rst_addr", 32'(csr_address), 32'd0);
        check("rst_wdata", 32'(csr_writedata), 32'd0);
        reset = 1'b0;
        wait_clk(10);

        // single write
        w0 = nwrites;
        exp_wr.push_back({5'h0C, 8'h34});
        txn_begin();
        xfer(8'h8C, 8, rx);
        xfer(8'h34, 8, rx);
        txn_end();
        check("t1_addr", 32'(csr_address), 32'h0C);
        check("t1_wdata", 32'(csr_writedata), 32'h34);
        check("t1_nwr", 32'(nwrites - w0), 32'd1);

        // burst write, fixed address
        w0 = nwrites;
        exp_wr.push_back({5'h15, 8'h11});
        exp_wr.push_back({5'h15, 8'h22});
        exp_wr.push_back({5'h15, 8'h33});
        txn_begin();
        xfer(8'h95, 8, rx);
        xfer(8'h11, 8, rx);
        xfer(8'h22, 8, rx);
        xfer(8'h33, 8, rx);
        txn_end();
        check("t2_nwr", 32'(nwrites - w0), 32'd3);
        check("t2_addr", 32'(csr_address), 32'h15);
        check("t2_wdata", 32'(csr_writedata), 32'h33);

        // single read; MOSI data must be ignored
        rd_base = 8'h0F; rd_mark = nreads; exp_rd_addr = 5'h00;
        r0 = nreads; w0 = nwrites;
        txn_begin();
        xfer(8'h00, 8, rx);
        xfer(8'hFF, 8, rx);
        txn_end();
        check("t3_miso", 32'(rx), 32'h0F);
        check("t3_nrd", 32'(nreads - r0), 32'd1);
        check("t3_nwr", 32'(nwrites - w0), 32'd0);

        // read burst with side-effecting CSR
        rd_base = 8'hA0; rd_mark = nreads; exp_rd_addr = 5'h15;
        r0 = nreads;
        txn_begin();
        xfer(8'h15, 8, rx);
        for (int k = 0; k < 4; k++) begin
            xfer(8'h5A, 8, rx);
            check($sformatf("t4_model_b%0d", k), 32'(rx), 32'(rd_base + 8'(k)));
            check($sformatf("t4_lit_b%0d", k), 32'(rx), 32'(lit4[k]));
        end
        txn_end();
        wait_clk(4 * HALF);
        check("t4_nrd", 32'(nreads - r0), 32'd4);

        // abort mid write byte, then clean transaction
        w0 = nwrites;
        txn_begin();
        xfer(8'h8C, 8, rx);
        xfer(8'hAB, 5, rx);
        txn_end();
        check("t5_no_wr", 32'(nwrites - w0), 32'd0);
        exp_wr.push_back({5'h03, 8'h5A});
        txn_begin();
        xfer(8'h83, 8, rx);
        xfer(8'h5A, 8, rx);
        txn_end();
        check("t5_nwr", 32'(nwrites - w0), 32'd1);
        check("t5_addr", 32'(csr_address), 32'h03);

        // reset during read byte 2
        rd_base = 8'h40; rd_mark = nreads; exp_rd_addr = 5'h15;
        r0 = nreads;
        txn_begin();
        xfer(8'h15, 8, rx);
        xfer(8'h00, 8, rx);
        check("t6_b1", 32'(rx), 32'h40);
        xfer(8'h00, 3, rx);
        check("t6_nrd", 32'(nreads - r0), 32'd2);
        reset = 1'b1;
        wait_clk(1);
        check("t6_rst_outs",
              32'({chip_select, spi_miso_oe, spi_miso, csr_read, csr_write,
                   csr_address, csr_writedata}), 32'd0);
        wait_clk(2);
        reset = 1'b0;
        wait_clk(3 * HALF);
        check("t6_no_strobe", 32'(nreads - r0), 32'd2);
        spi_nss = 1'b1;
        wait_clk(2 * HALF);
        w0 = nwrites;
        exp_wr.push_back({5'h04, 8'h07});
        txn_begin();
        xfer(8'h84, 8, rx);
        xfer(8'h07, 8, rx);
        txn_end();
        check("t6_nwr", 32'(nwrites - w0), 32'd1);
        check("t6_addr", 32'(csr_address), 32'h04);
        check("t6_wdata", 32'(csr_writedata), 32'h07);

        wait_clk(10);
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
